// File: rtl/writeback_buffer_pkg.sv
// Shared widths, line-tag helper and drain FSM states for the writeback buffer.
package writeback_buffer_pkg;

  localparam int unsigned WB_ADDR_W      = 32;
  localparam int unsigned WB_LINE_W      = 512;
  localparam int unsigned WB_OFFSET_BITS = 6;

  typedef enum logic {
    IDLE,
    WRITE
  } wb_state_e;

  // Result is right-aligned; callers truncate to their own tag width.
  function automatic logic [WB_ADDR_W-1:0] line_tag(input logic [WB_ADDR_W-1:0] addr,
                                                    input int unsigned offset_bits);
    return addr >> offset_bits;
  endfunction

endpackage

// File: rtl/writeback_buffer_match.sv
// Combinational line match over the buffer entries; reports the youngest matching slot.
module wb_match_unit
  import writeback_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_W      = WB_ADDR_W,
  parameter int unsigned OFFSET_BITS = WB_OFFSET_BITS
) (
  input  logic [ADDR_W-OFFSET_BITS-1:0] tags [DEPTH],
  input  logic [DEPTH-1:0]              valid,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [ADDR_W-1:0]             address,
  output logic                          hit,
  output logic [$clog2(DEPTH)-1:0]      idx
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = ADDR_W - OFFSET_BITS;

  logic [TAG_W-1:0] cmp_tag;
  logic [PTR_W-1:0] slot;

  assign cmp_tag = TAG_W'(line_tag(WB_ADDR_W'(address), OFFSET_BITS));

  // Walk from head toward tail so a later match overrides an older one.
  always_comb begin
    hit  = 1'b0;
    idx  = head;
    slot = head;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (valid[slot] && (tags[slot] == cmp_tag)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Dirty-line writeback queue: coalesces evictions, drains to RAM by req/ack, and
// answers combinational snoops so fills never see stale RAM data.
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_W      = WB_ADDR_W,
  parameter int unsigned LINE_W      = WB_LINE_W,
  parameter int unsigned OFFSET_BITS = WB_OFFSET_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     evict_valid,
  input  logic [ADDR_W-1:0]        evict_address,
  input  logic [LINE_W-1:0]        evict_data,
  output logic                     evict_ready,
  output logic                     ram_wr_req,
  output logic [ADDR_W-1:0]        ram_wr_address,
  output logic [LINE_W-1:0]        ram_wr_data,
  input  logic                     ram_wr_ready,
  input  logic [ADDR_W-1:0]        lookup_address,
  output logic                     lookup_hit,
  output logic [LINE_W-1:0]        lookup_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TAG_W = ADDR_W - OFFSET_BITS;

  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  wb_state_e         state_q, state_d;

  logic              push, pop, alloc;
  logic              co_hit, sn_hit;
  logic [PTR_W-1:0]  co_idx, sn_idx;
  logic [DEPTH-1:0]  co_valid;
  logic [TAG_W-1:0]  evict_tag;

  assign evict_tag   = TAG_W'(line_tag(WB_ADDR_W'(evict_address), OFFSET_BITS));
  assign evict_ready = (count_q < CNT_W'(DEPTH));
  assign push        = evict_valid && evict_ready;
  assign pop         = (state_q == WRITE) && ram_wr_ready;
  assign alloc       = push && !co_hit;

  // The in-flight head must keep its data stable, so it is hidden from coalescing.
  always_comb begin
    co_valid = valid_q;
    if (state_q == WRITE) begin
      co_valid[head_q] = 1'b0;
    end
  end

  wb_match_unit #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .OFFSET_BITS (OFFSET_BITS)
  ) u_coalesce (
    .tags    (tag_q),
    .valid   (co_valid),
    .head    (head_q),
    .address (evict_address),
    .hit     (co_hit),
    .idx     (co_idx)
  );

  wb_match_unit #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .OFFSET_BITS (OFFSET_BITS)
  ) u_snoop (
    .tags    (tag_q),
    .valid   (valid_q),
    .head    (head_q),
    .address (lookup_address),
    .hit     (sn_hit),
    .idx     (sn_idx)
  );

  assign count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_d != '0) state_d = WRITE;
      WRITE:   if (ram_wr_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
    end
  end

  // Payload storage needs no reset: every read is qualified by a valid bit or the FSM.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[tail_q]  <= evict_tag;
      data_q[tail_q] <= evict_data;
    end else if (push) begin
      data_q[co_idx] <= evict_data;
    end
  end

  assign ram_wr_req     = (state_q == WRITE);
  assign ram_wr_address = ram_wr_req ? {tag_q[head_q], {OFFSET_BITS{1'b0}}} : '0;
  assign ram_wr_data    = ram_wr_req ? data_q[head_q] : '0;
  assign lookup_hit     = sn_hit;
  assign lookup_data    = sn_hit ? data_q[sn_idx] : '0;
  assign empty          = (count_q == '0);
  assign count          = count_q;

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_writeback_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         evict_valid = 1'b0;
  logic [31:0]  evict_address = '0;
  logic [511:0] evict_data = '0;
  logic         evict_ready;
  logic         ram_wr_req;
  logic [31:0]  ram_wr_address;
  logic [511:0] ram_wr_data;
  logic         ram_wr_ready = 1'b0;
  logic [31:0]  lookup_address = '0;
  logic         lookup_hit;
  logic [511:0] lookup_data;
  logic         empty;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  writeback_buffer #(
    .DEPTH       (4),
    .ADDR_W      (32),
    .LINE_W      (512),
    .OFFSET_BITS (6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .evict_valid    (evict_valid),
    .evict_address  (evict_address),
    .evict_data     (evict_data),
    .evict_ready    (evict_ready),
    .ram_wr_req     (ram_wr_req),
    .ram_wr_address (ram_wr_address),
    .ram_wr_data    (ram_wr_data),
    .ram_wr_ready   (ram_wr_ready),
    .lookup_address (lookup_address),
    .lookup_hit     (lookup_hit),
    .lookup_data    (lookup_data),
    .empty          (empty),
    .count          (count)
  );

  always #5 clk = ~clk;

  // Model: oldest line at index 0; m_write means a RAM write of mq[0] is outstanding.
  typedef struct {
    logic [25:0]  tag;
    logic [511:0] data;
  } ent_t;

  ent_t mq[$];
  bit   m_write = 1'b0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void m_snoop(input logic [31:0] a, output bit hit, output logic [511:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].tag == a[31:6]) begin
        hit = 1'b1;
        d   = mq[i].data;
        break;
      end
    end
  endfunction

  // One clock cycle: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic cycle(input bit ev, input logic [31:0] ea, input logic [511:0] ed,
                       input bit ack, input logic [31:0] la);
    bit           hit, push, pop;
    logic [511:0] sd, exp_data;
    logic [31:0]  exp_addr;
    int           idx, lo;
    ent_t         e;
    evict_valid    = ev;
    evict_address  = ea;
    evict_data     = ed;
    ram_wr_ready   = ack;
    lookup_address = la;
    #1;
    m_snoop(la, hit, sd);
    exp_addr = '0;
    exp_data = '0;
    if (m_write) begin
      exp_addr = {mq[0].tag, 6'b0};
      exp_data = mq[0].data;
    end
    check("evict_ready", 512'(evict_ready), 512'(mq.size() < 4));
    check("ram_wr_req", 512'(ram_wr_req), 512'(m_write));
    check("ram_wr_address", 512'(ram_wr_address), 512'(exp_addr));
    check("ram_wr_data", ram_wr_data, exp_data);
    check("count", 512'(count), 512'(mq.size()));
    check("empty", 512'(empty), 512'(mq.size() == 0));
    check("lookup_hit", 512'(lookup_hit), 512'(hit));
    check("lookup_data", lookup_data, sd);
    @(posedge clk);
    push = ev && (mq.size() < 4);
    pop  = m_write && ack;
    if (push) begin
      idx = -1;
      lo  = m_write ? 1 : 0;
      for (int i = mq.size() - 1; i >= lo; i--) begin
        if (mq[i].tag == ea[31:6]) begin
          idx = i;
          break;
        end
      end
      if (idx >= 0) mq[idx].data = ed;
      else begin
        e.tag  = ea[31:6];
        e.data = ed;
        mq.push_back(e);
      end
    end
    if (pop) void'(mq.pop_front());
    if (m_write) m_write = !ack;
    else         m_write = (mq.size() > 0);
    #1;
  endtask

  task automatic idle(input int n, input logic [31:0] la);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, la);
  endtask

  task automatic drain(input logic [31:0] la);
    int n = 0;
    while ((mq.size() != 0 || m_write) && n < 60) begin
      cycle(1'b0, '0, '0, m_write, la);
      n++;
    end
    check("drained_empty", 512'(empty), 512'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] da, db, dc;
    logic [511:0] d5 [5];
    logic [31:0]  a;

    // Reset values while rst is held
    #2;
    check("rst_req", 512'(ram_wr_req), 512'(1'b0));
    check("rst_ready", 512'(evict_ready), 512'(1'b1));
    check("rst_empty", 512'(empty), 512'(1'b1));
    check("rst_hit", 512'(lookup_hit), 512'(1'b0));
    check("rst_count", 512'(count), 512'(0));
    check("rst_addr", 512'(ram_wr_address), 512'(0));
    check("rst_ldata", lookup_data, 512'(0));
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single evict, RAM acks three cycles after the request
    da = rnd_line();
    cycle(1'b1, 32'h0000_1040, da, 1'b0, 32'h0000_1040);
    check("t1_req_rise", 512'(ram_wr_req), 512'(1'b1));
    check("t1_addr", 512'(ram_wr_address), 512'(32'h0000_1040));
    idle(2, 32'h0000_1040);
    cycle(1'b0, '0, '0, 1'b1, 32'h0000_1040);
    check("t1_count_after_ack", 512'(count), 512'(0));
    check("t1_empty_after_ack", 512'(empty), 512'(1'b1));
    idle(2, 32'h0000_1040);

    // 2: overfill with no ack; fifth line held until after the first ack
    for (int i = 0; i < 5; i++) d5[i] = rnd_line();
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_4000 + 32'(i) * 32'h40, d5[i], 1'b0, 32'h0000_4100);
    check("t2_full_count", 512'(count), 512'(4));
    check("t2_not_ready", 512'(evict_ready), 512'(1'b0));
    cycle(1'b1, 32'h0000_4100, d5[4], 1'b1, 32'h0000_4100);
    check("t2_ready_after_ack", 512'(evict_ready), 512'(1'b1));
    cycle(1'b1, 32'h0000_4100, d5[4], 1'b0, 32'h0000_4100);
    check("t2_fifth_in", 512'(count), 512'(4));
    drain(32'h0000_4100);

    // 3a: coalesce behind an unrelated in-flight head
    da = rnd_line();
    db = rnd_line();
    cycle(1'b1, 32'h0000_8000, rnd_line(), 1'b0, 32'h0000_2000);
    cycle(1'b1, 32'h0000_2000, da, 1'b0, 32'h0000_2000);
    cycle(1'b1, 32'h0000_2010, db, 1'b0, 32'h0000_2000);
    check("t3a_count", 512'(count), 512'(2));
    check("t3a_snoop", lookup_data, db);
    drain(32'h0000_2000);

    // 3b: same line as the in-flight head allocates a fresh entry
    cycle(1'b1, 32'h0000_2000, da, 1'b0, 32'h0000_2000);
    cycle(1'b1, 32'h0000_2010, db, 1'b0, 32'h0000_2000);
    check("t3b_count", 512'(count), 512'(2));
    check("t3b_snoop", lookup_data, db);
    check("t3b_head_data", ram_wr_data, da);
    idle(2, 32'h0000_2000);
    drain(32'h0000_2000);

    // 4: push and pop on the same edge, enough times to wrap the pointers
    cycle(1'b1, 32'h0000_A000, rnd_line(), 1'b0, 32'h0000_A040);
    cycle(1'b1, 32'h0000_A040, rnd_line(), 1'b0, 32'h0000_A040);
    for (int i = 0; i < 12; i++) begin
      a = 32'h0000_B000 + 32'(i) * 32'h40;
      cycle(m_write, a, rnd_line(), m_write, a);
    end
    check("t4_count", 512'(count), 512'(2));
    drain(32'h0000_B000);

    // 5: snoop miss, hit, then miss after the line drains
    dc = rnd_line();
    idle(1, 32'h0000_3000);
    check("t5_miss_empty", 512'(lookup_hit), 512'(1'b0));
    cycle(1'b1, 32'h0000_3000, dc, 1'b0, 32'h0000_3000);
    check("t5_hit", 512'(lookup_hit), 512'(1'b1));
    check("t5_data", lookup_data, dc);
    drain(32'h0000_3000);
    idle(1, 32'h0000_3000);
    check("t5_miss_after", 512'(lookup_hit), 512'(1'b0));

    // Random traffic over a small line set so coalescing is frequent
    for (int i = 0; i < 300; i++) begin
      a = 32'h0001_0000 + 32'($urandom_range(0, 7)) * 32'h40 + 32'($urandom_range(0, 63));
      cycle(($urandom_range(0, 2) != 0), a, rnd_line(), m_write && ($urandom_range(0, 1) == 1),
            32'h0001_0000 + 32'($urandom_range(0, 8)) * 32'h40);
    end
    drain(32'h0001_0000);

    // 6: asynchronous reset in the middle of a write
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_C000 + 32'(i) * 32'h40, rnd_line(), 1'b0, '0);
    check("t6_pre_req", 512'(ram_wr_req), 512'(1'b1));
    check("t6_pre_count", 512'(count), 512'(3));
    evict_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_req_async", 512'(ram_wr_req), 512'(1'b0));
    check("t6_count", 512'(count), 512'(0));
    check("t6_ready", 512'(evict_ready), 512'(1'b1));
    mq.delete();
    m_write = 1'b0;
    #1 rst = 1'b0;
    idle(4, 32'h0000_C000);
    cycle(1'b1, 32'h0000_D000, rnd_line(), 1'b0, 32'h0000_D000);
    drain(32'h0000_D000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
